// File: rtl/reset_run_pkg.sv
// rtl/reset_run_pkg.sv - shared state encoding, release schedule and counter limits
package reset_run_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_e;

    localparam int unsigned MAX_CNT_W = 64;
    localparam logic [MAX_CNT_W-1:0] CNT_MAX = '1;

    // Edge number (E1 = first edge out of reset) on which domain k leaves reset.
    function automatic int unsigned release_edge(
        input int unsigned hold_cycles,
        input int unsigned stagger_cycles,
        input int unsigned k
    );
        return hold_cycles + k * stagger_cycles;
    endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// rtl/run_cycle_counter.sv - saturating run-cycle counter with next-equals-limit compare
module run_cycle_counter
    import reset_run_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] count_o,
    output logic             next_eq_limit_o
);

    localparam logic [CNT_W-1:0] SAT = CNT_MAX[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_max;

    assign at_max = (count_q == SAT);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !at_max) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A zero limit means unlimited; the at_max guard keeps count+1 from wrapping into a false match.
    assign next_eq_limit_o = (limit_i != '0) && !at_max && ((count_q + ONE) == limit_i);
    assign count_o         = count_q;

endmodule

// File: rtl/reset_run_sequencer.sv
// rtl/reset_run_sequencer.sv - staggered domain reset release, run-cycle counting and end-of-run control
module reset_run_sequencer
    import reset_run_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS    = 2,
    parameter int unsigned HOLD_CYCLES    = 10,
    parameter int unsigned STAGGER_CYCLES = 2,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   soft_reset_i,
    input  logic                   halt_i,
    input  logic [CNT_W-1:0]       run_limit_i,
    output logic [NUM_DOMAINS-1:0] dom_reset_n_o,
    output logic                   running_o,
    output logic                   done_o,
    output logic                   timeout_o,
    output logic [CNT_W-1:0]       cycle_count_o
);

    seq_state_e             state_q, state_d;
    logic [31:0]            seq_cnt_q, seq_cnt_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   timeout_q, timeout_d;
    logic [CNT_W-1:0]       limit_q, limit_d;
    logic                   cnt_clr;
    logic                   cnt_en;
    logic                   limit_hit;

    always_comb begin
        state_d   = state_q;
        seq_cnt_d = seq_cnt_q;
        dom_d     = dom_q;
        timeout_d = timeout_q;
        limit_d   = limit_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        if (soft_reset_i) begin
            state_d   = ST_HOLD;
            seq_cnt_d = '0;
            dom_d     = '0;
            timeout_d = 1'b0;
            limit_d   = '0;
            cnt_clr   = 1'b1;
        end else begin
            case (state_q)
                ST_HOLD, ST_RELEASE: begin
                    // seq_cnt_d is the number of the edge being taken, so compare it to the schedule directly.
                    seq_cnt_d = seq_cnt_q + 32'd1;
                    for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
                        if (seq_cnt_d >= release_edge(HOLD_CYCLES, STAGGER_CYCLES, k)) begin
                            dom_d[k] = 1'b1;
                        end
                    end
                    if (&dom_d) begin
                        state_d = ST_RUN;
                        limit_d = run_limit_i;
                        cnt_clr = 1'b1;
                    end else if (dom_d[0]) begin
                        state_d = ST_RELEASE;
                    end
                end
                ST_RUN: begin
                    if (halt_i) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b0;
                    end else begin
                        cnt_en = 1'b1;
                        if (limit_hit) begin
                            state_d   = ST_DONE;
                            timeout_d = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_HOLD;
            seq_cnt_q <= '0;
            dom_q     <= '0;
            timeout_q <= 1'b0;
            limit_q   <= '0;
        end else begin
            state_q   <= state_d;
            seq_cnt_q <= seq_cnt_d;
            dom_q     <= dom_d;
            timeout_q <= timeout_d;
            limit_q   <= limit_d;
        end
    end

    run_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk             (clk),
        .reset           (reset),
        .clr_i           (cnt_clr),
        .en_i            (cnt_en),
        .limit_i         (limit_q),
        .count_o         (cycle_count_o),
        .next_eq_limit_o (limit_hit)
    );

    assign dom_reset_n_o = dom_q;
    assign running_o     = (state_q == ST_RUN);
    assign done_o        = (state_q == ST_DONE);
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_reset_run_sequencer.sv
// tb/tb_reset_run_sequencer.sv - directed self-checking bench for reset_run_sequencer
module tb_reset_run_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        soft_reset_i = 1'b0;
    logic        halt_i = 1'b0;
    logic [31:0] run_limit_i = 32'd0;

    logic [1:0]  dom2;
    logic        run2, done2, tmo2;
    logic [31:0] cnt2;
    logic [3:0]  dom4;
    logic        run4, done4, tmo4;
    logic [31:0] cnt4;

    int errors = 0;
    int checks = 0;
    int e = 0;

    always #5 clk = ~clk;

    reset_run_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .soft_reset_i  (soft_reset_i),
        .halt_i        (halt_i),
        .run_limit_i   (run_limit_i),
        .dom_reset_n_o (dom2),
        .running_o     (run2),
        .done_o        (done2),
        .timeout_o     (tmo2),
        .cycle_count_o (cnt2)
    );

    reset_run_sequencer #(
        .NUM_DOMAINS    (4),
        .STAGGER_CYCLES (0)
    ) dut4 (
        .clk           (clk),
        .reset         (reset),
        .soft_reset_i  (soft_reset_i),
        .halt_i        (halt_i),
        .run_limit_i   (run_limit_i),
        .dom_reset_n_o (dom4),
        .running_o     (run4),
        .done_o        (done4),
        .timeout_o     (tmo4),
        .cycle_count_o (cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at E%0d: observed=%0h expected=%0h", tag, e, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic step_to(input int n);
        while (e < n) step();
    endtask

    task automatic soft_restart();
        soft_reset_i = 1'b1;
        step();
        soft_reset_i = 1'b0;
        e = 0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_dom"}, 64'(dom2), 64'd0);
        chk({tag, "_run"}, 64'(run2), 64'd0);
        chk({tag, "_done"}, 64'(done2), 64'd0);
        chk({tag, "_tmo"}, 64'(tmo2), 64'd0);
        chk({tag, "_cnt"}, 64'(cnt2), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_cleared("rst");
        chk("rst_dom4", 64'(dom4), 64'd0);

        // Defaults, limit 110; limit change after RUN entry must be ignored
        run_limit_i = 32'd110;
        @(negedge clk);
        reset = 1'b0;
        e = 0;
        step_to(9);
        chk("e9_dom", 64'(dom2), 64'h0);
        chk("e9_dom4", 64'(dom4), 64'h0);
        step_to(10);
        chk("e10_dom", 64'(dom2), 64'h1);
        chk("e10_run", 64'(run2), 64'd0);
        chk("e10_dom4", 64'(dom4), 64'hf);
        chk("e10_run4", 64'(run4), 64'd1);
        step_to(11);
        chk("e11_dom", 64'(dom2), 64'h1);
        step_to(12);
        chk("e12_dom", 64'(dom2), 64'h3);
        chk("e12_run", 64'(run2), 64'd1);
        chk("e12_cnt", 64'(cnt2), 64'd0);
        step_to(13);
        run_limit_i = 32'd50;
        step_to(62);
        chk("e62_cnt", 64'(cnt2), 64'd50);
        chk("e62_done", 64'(done2), 64'd0);
        step_to(121);
        chk("e121_cnt", 64'(cnt2), 64'd109);
        chk("e121_done", 64'(done2), 64'd0);
        step_to(122);
        chk("lim_done", 64'(done2), 64'd1);
        chk("lim_tmo", 64'(tmo2), 64'd1);
        chk("lim_cnt", 64'(cnt2), 64'd110);
        chk("lim_run", 64'(run2), 64'd0);
        step_to(125);
        chk("frz_cnt", 64'(cnt2), 64'd110);
        chk("frz_dom", 64'(dom2), 64'h3);
        chk("frz_done", 64'(done2), 64'd1);

        // Soft reset out of DONE, then soft reset mid-RUN at E60
        soft_restart();
        chk_cleared("sr1");
        run_limit_i = 32'd0;
        step_to(59);
        chk("e59_cnt", 64'(cnt2), 64'd47);
        soft_reset_i = 1'b1;
        step();
        soft_reset_i = 1'b0;
        chk_cleared("sr_run");
        e = 0;
        step_to(9);
        chk("re_e9_dom", 64'(dom2), 64'h0);
        step_to(10);
        chk("re_e10_dom", 64'(dom2), 64'h1);

        // Unlimited run ended by halt at E50
        step_to(49);
        chk("e49_cnt", 64'(cnt2), 64'd37);
        halt_i = 1'b1;
        step();
        halt_i = 1'b0;
        chk("halt_done", 64'(done2), 64'd1);
        chk("halt_tmo", 64'(tmo2), 64'd0);
        chk("halt_cnt", 64'(cnt2), 64'd37);
        step();
        chk("halt_frz", 64'(cnt2), 64'd37);

        // Halt ignored in HOLD/RELEASE; halt and limit on the same edge
        soft_restart();
        run_limit_i = 32'd5;
        halt_i = 1'b1;
        step_to(12);
        chk("hh_run", 64'(run2), 64'd1);
        chk("hh_cnt", 64'(cnt2), 64'd0);
        halt_i = 1'b0;
        step_to(16);
        chk("e16_cnt", 64'(cnt2), 64'd4);
        chk("e16_done", 64'(done2), 64'd0);
        halt_i = 1'b1;
        step();
        halt_i = 1'b0;
        chk("hl_done", 64'(done2), 64'd1);
        chk("hl_tmo", 64'(tmo2), 64'd0);
        chk("hl_cnt", 64'(cnt2), 64'd4);

        // Asynchronous reset between edges at E30, then clean restart
        soft_restart();
        run_limit_i = 32'd0;
        step_to(30);
        chk("e30_cnt", 64'(cnt2), 64'd18);
        #2;
        reset = 1'b1;
        #1;
        chk_cleared("arst");
        @(negedge clk);
        reset = 1'b0;
        e = 0;
        step_to(10);
        chk("ar_e10_dom", 64'(dom2), 64'h1);
        chk("ar_e10_run", 64'(run2), 64'd0);
        step_to(12);
        chk("ar_e12_dom", 64'(dom2), 64'h3);
        chk("ar_e12_run", 64'(run2), 64'd1);
        step_to(15);
        chk("ar_e15_cnt", 64'(cnt2), 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
